phv_queue_merger: RTL and testbench
===================================

Name: phv_queue_merger

Overview:
- Receiving end of the last stage's per-queue PHV fan-out: accepts the C_NUM_QUEUES per-queue PHV streams (phv/valid/ready per queue) and merges them round-robin into one registered PHV stream for a shared deparser or recirculation path.
- Each emitted PHV carries a one-hot queue field naming the queue it was taken from.
- Keeps per-queue accept counters and sticky queue-mismatch flags.

Parameters:
- PHV_LEN, 6400 (48*64+32*64+16*64+256): PHV width in bits.
- C_NUM_QUEUES, 4: number of input queues; only 4 is supported.
- QUEUE_BIT_OFF, 141: LSB of the one-hot queue field, PHV[QUEUE_BIT_OFF+:C_NUM_QUEUES].
- CNT_WIDTH, 32: width of each per-queue counter.

Ports:
- axis_clk  in  1  single clock; all logic is on the rising edge.
- axis_rst  in  1  synchronous, active-high reset.
- phv_in  in  C_NUM_QUEUES*PHV_LEN  queue i occupies bits [i*PHV_LEN+:PHV_LEN].
- phv_in_valid  in  C_NUM_QUEUES  per-queue valid.
- phv_in_ready  out  C_NUM_QUEUES  per-queue ready; driven only from registers.
- phv_out  out  PHV_LEN  merged PHV.
- phv_out_valid  out  1  output valid.
- phv_out_ready  in  1  downstream ready.
- queue_idx_out  out  2  binary index of the source queue, aligned with phv_out.
- q_cnt  out  C_NUM_QUEUES*CNT_WIDTH  per-queue accepted-PHV counters.
- q_err  out  C_NUM_QUEUES  sticky flag: a PHV arrived on queue i without bit QUEUE_BIT_OFF+i set.

Behaviour:
- Reset (axis_rst=1 on a clock edge):
  - in_buf_vld=0, rr_ptr=0, phv_out_valid=0, phv_out=0, queue_idx_out=0, q_cnt=0, q_err=0, phv_in_ready=0.
  - First cycle after reset deasserts: phv_in_ready = all ones.
  - Reset mid-operation silently discards all buffered or in-flight PHVs.
- Input buffer, one entry per queue:
  - phv_in_ready[i] = ~in_buf_vld[i], registered.
  - Accept on queue i when phv_in_valid[i] && phv_in_ready[i]. On accept: store the PHV, set in_buf_vld[i], increment q_cnt[i] (wraps 2^CNT_WIDTH-1 -> 0).
  - If bit QUEUE_BIT_OFF+i of the accepted PHV is 0, set q_err[i]; it stays set until reset. The PHV is still forwarded.
  - Per-queue throughput: at most 1 PHV per 2 cycles. Aggregate throughput: 1 PHV per cycle when all queues are busy.
- Output slot: "free" when ~phv_out_valid || phv_out_ready.
- Arbitration, each cycle the output slot is free and any in_buf_vld is set:
  - Winner w = first set in_buf_vld scanning rr_ptr, rr_ptr+1, ... modulo 4.
  - Load phv_out = buffered PHV of queue w, with field [QUEUE_BIT_OFF+:4] replaced by one-hot(w). Multicast copies therefore leave as unicast.
  - Set queue_idx_out=w, phv_out_valid=1, clear in_buf_vld[w], rr_ptr <= (w+1) mod 4.
- If the slot is free and no buffer is valid: phv_out_valid <= 0.
- If the slot is not free (valid && ~ready): hold phv_out, queue_idx_out and rr_ptr stable; buffers keep filling.
- Latency: input accepted at edge N -> buffered after N -> phv_out_valid after edge N+1, given no contention and a free slot.
- Same cycle on queue w:
  - Clearing in_buf_vld[w] by a grant is never concurrent with an accept on w, because ready was 0.
  - The next accept on w occurs one cycle after the grant.
- Starvation bound: a buffered queue is granted within 4 output handshakes.
- All four queues loading the same cycle, starting at rr_ptr=0: output order 0,1,2,3.

Decomposition:
- Shared package (phv_pkg):
  - PHV_LEN and QUEUE_BIT_OFF constants.
  - C_NUM_QUEUES.
  - Queue-index typedef (2 bits).
  - Function onehot_to_idx.
- Sub-module rr_arbiter_4:
  - Inputs: request vector, rr_ptr, grant enable.
  - Outputs: one-hot grant, binary index, any_grant.
  - Purely combinational. rr_ptr stays as a register in the parent.

Test Plan:
- Reset, then a single PHV on queue 2 with bit 143=1 and out_ready=1 -> phv_out_valid after 2 cycles, queue_idx_out=2, field[141+:4]=4'b0100, q_cnt[2]=1, q_err=0.
- All four queues valid in the same cycle, out_ready=1 -> outputs on 4 consecutive cycles with queue_idx 0,1,2,3; phv_in_ready returns high for each queue one cycle after its grant.
- Multicast PHV with field 4'b1111 pushed to queues 0 and 3 -> two outputs, fields 4'b0001 then 4'b1000, payload otherwise identical.
- Hold out_ready=0 for 10 cycles with all queues loaded -> phv_out stable, all phv_in_ready=0; release -> order continues from rr_ptr, no loss or duplication.
- PHV on queue 1 with bit 142=0 -> forwarded with field 4'b0010, q_err[1]=1 and sticky; cleared only by axis_rst.
- Assert axis_rst with 3 buffers full and output valid -> next cycle phv_out_valid=0, q_cnt=0, rr_ptr=0; no buffered PHV appears after reset.

Source files
------------

// File: rtl/phv_pkg.sv
// Shared constants, queue-index type and helper for the per-queue PHV merger.
package phv_pkg;

    localparam int PHV_LEN       = 6400;
    localparam int C_NUM_QUEUES  = 4;
    localparam int QUEUE_BIT_OFF = 141;
    localparam int CNT_WIDTH     = 32;

    typedef logic [1:0] queue_idx_t;

    function automatic queue_idx_t onehot_to_idx(input logic [3:0] onehot);
        case (onehot)
            4'b0010: onehot_to_idx = 2'd1;
            4'b0100: onehot_to_idx = 2'd2;
            4'b1000: onehot_to_idx = 2'd3;
            default: onehot_to_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/phv_queue_merger_rr_arbiter.sv
// Combinational 4-way round-robin arbiter; the pointer register lives in the parent.
module rr_arbiter_4
    import phv_pkg::*;
(
    input  logic [3:0] req,
    input  queue_idx_t rr_ptr,
    input  logic       en,
    output logic [3:0] grant,
    output queue_idx_t idx,
    output logic       any_grant
);

    logic [3:0] pick;

    // Scan from the farthest position back to rr_ptr so the last hit is the first in rotation.
    always_comb begin
        pick = '0;
        for (int k = 3; k >= 0; k--) begin
            if (req[queue_idx_t'(rr_ptr + queue_idx_t'(k))]) begin
                pick = 4'b0001 << queue_idx_t'(rr_ptr + queue_idx_t'(k));
            end
        end
    end

    assign grant     = en ? pick : 4'b0000;
    assign idx       = onehot_to_idx(pick);
    assign any_grant = en && (|req);

endmodule

// File: rtl/phv_queue_merger.sv
// Merges four per-queue PHV streams round-robin into one registered stream, tagging the source queue.
module phv_queue_merger
    import phv_pkg::*;
(
    input  logic                              axis_clk,
    input  logic                              axis_rst,
    input  logic [C_NUM_QUEUES*PHV_LEN-1:0]   phv_in,
    input  logic [C_NUM_QUEUES-1:0]           phv_in_valid,
    output logic [C_NUM_QUEUES-1:0]           phv_in_ready,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_out_valid,
    input  logic                              phv_out_ready,
    output logic [1:0]                        queue_idx_out,
    output logic [C_NUM_QUEUES*CNT_WIDTH-1:0] q_cnt,
    output logic [C_NUM_QUEUES-1:0]           q_err
);

    logic [C_NUM_QUEUES-1:0] in_buf_vld;
    logic [C_NUM_QUEUES-1:0] grant;
    queue_idx_t              grant_idx;
    logic                    any_grant;
    logic                    slot_free;
    logic [PHV_LEN-1:0]      buf_data [C_NUM_QUEUES];
    logic [PHV_LEN-1:0]      sel_phv;

    queue_idx_t              rr_ptr_reg;
    logic                    phv_out_valid_reg;
    logic [PHV_LEN-1:0]      phv_out_reg;
    queue_idx_t              queue_idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_QUEUES; gi++) begin : g_queue
            logic                 vld_reg;
            logic                 ready_reg;
            logic                 err_reg;
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic [PHV_LEN-1:0]   data_reg;
            logic                 accept;
            logic                 vld_next;

            assign accept   = phv_in_valid[gi] & ready_reg;
            // A grant and an accept never coincide on one queue: ready is low while the buffer is full.
            assign vld_next = (vld_reg & ~grant[gi]) | accept;

            always_ff @(posedge axis_clk) begin
                if (axis_rst) begin
                    vld_reg   <= 1'b0;
                    ready_reg <= 1'b0;
                    cnt_reg   <= '0;
                    err_reg   <= 1'b0;
                end else begin
                    vld_reg   <= vld_next;
                    ready_reg <= ~vld_next;
                    if (accept) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (!phv_in[gi*PHV_LEN + QUEUE_BIT_OFF + gi]) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge axis_clk) begin
                if (accept) begin
                    data_reg <= phv_in[gi*PHV_LEN +: PHV_LEN];
                end
            end

            assign in_buf_vld[gi]                     = vld_reg;
            assign phv_in_ready[gi]                   = ready_reg;
            assign q_err[gi]                          = err_reg;
            assign q_cnt[gi*CNT_WIDTH +: CNT_WIDTH]   = cnt_reg;
            assign buf_data[gi]                       = data_reg;
        end
    endgenerate

    assign slot_free = ~phv_out_valid_reg | phv_out_ready;

    rr_arbiter_4 u_arb (
        .req       (in_buf_vld),
        .rr_ptr    (rr_ptr_reg),
        .en        (slot_free),
        .grant     (grant),
        .idx       (grant_idx),
        .any_grant (any_grant)
    );

    // Outgoing PHVs always carry a unicast tag for the queue they came from.
    always_comb begin
        sel_phv = buf_data[grant_idx];
        sel_phv[QUEUE_BIT_OFF +: C_NUM_QUEUES] = grant;
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            rr_ptr_reg        <= '0;
            phv_out_valid_reg <= 1'b0;
            phv_out_reg       <= '0;
            queue_idx_reg     <= '0;
        end else if (any_grant) begin
            phv_out_reg       <= sel_phv;
            queue_idx_reg     <= grant_idx;
            phv_out_valid_reg <= 1'b1;
            rr_ptr_reg        <= grant_idx + queue_idx_t'(1);
        end else if (slot_free) begin
            phv_out_valid_reg <= 1'b0;
        end
    end

    assign phv_out       = phv_out_reg;
    assign phv_out_valid = phv_out_valid_reg;
    assign queue_idx_out = queue_idx_reg;

endmodule

// File: tb/tb_phv_queue_merger.sv
// Directed self-checking bench for phv_queue_merger.
module tb_phv_queue_merger;
    import phv_pkg::*;

    logic                              axis_clk = 1'b0;
    logic                              axis_rst;
    logic [C_NUM_QUEUES*PHV_LEN-1:0]   phv_in;
    logic [C_NUM_QUEUES-1:0]           phv_in_valid;
    logic [C_NUM_QUEUES-1:0]           phv_in_ready;
    logic [PHV_LEN-1:0]                phv_out;
    logic                              phv_out_valid;
    logic                              phv_out_ready;
    logic [1:0]                        queue_idx_out;
    logic [C_NUM_QUEUES*CNT_WIDTH-1:0] q_cnt;
    logic [C_NUM_QUEUES-1:0]           q_err;

    int tests_run    = 0;
    int tests_failed = 0;

    phv_queue_merger dut (
        .axis_clk      (axis_clk),
        .axis_rst      (axis_rst),
        .phv_in        (phv_in),
        .phv_in_valid  (phv_in_valid),
        .phv_in_ready  (phv_in_ready),
        .phv_out       (phv_out),
        .phv_out_valid (phv_out_valid),
        .phv_out_ready (phv_out_ready),
        .queue_idx_out (queue_idx_out),
        .q_cnt         (q_cnt),
        .q_err         (q_err)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) begin
        if (!axis_rst && phv_out_valid && phv_out_ready)
            $display("[TB] out q=%0d field=%b lsw=%h", queue_idx_out, phv_out[QUEUE_BIT_OFF +: 4], phv_out[31:0]);
    end

    function automatic logic [PHV_LEN-1:0] make_phv(input logic [31:0] seed, input logic [3:0] field);
        logic [PHV_LEN-1:0] p;
        p = '0;
        for (int i = 0; i < PHV_LEN/32; i++)
            p[i*32 +: 32] = seed ^ (32'(i) * 32'h9E37_79B9);
        p[QUEUE_BIT_OFF +: 4] = field;
        return p;
    endfunction

    task automatic tick();
        @(posedge axis_clk);
        @(negedge axis_clk);
    endtask

    task automatic do_reset();
        axis_rst = 1'b1;
        tick();
        axis_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        axis_rst = 1'b1; phv_in = '0; phv_in_valid = '0; phv_out_ready = 1'b0;
        tick(); tick();
        tests_run++; if (phv_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", phv_out_valid); end
        tests_run++; if (phv_in_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready got=%b exp=0000", phv_in_ready); end
        tests_run++; if (q_cnt !== '0) begin tests_failed++; $display("FAIL reset_cnt got=%h exp=0", q_cnt); end
        tests_run++; if (q_err !== 4'b0000) begin tests_failed++; $display("FAIL reset_err got=%b exp=0000", q_err); end
        tests_run++; if (queue_idx_out !== 2'd0 || phv_out !== '0) begin tests_failed++; $display("FAIL reset_out got idx=%0d lsw=%h exp 0", queue_idx_out, phv_out[31:0]); end
        axis_rst = 1'b0;
        tick();
        tests_run++; if (phv_in_ready !== 4'b1111) begin tests_failed++; $display("FAIL post_reset_ready got=%b exp=1111", phv_in_ready); end
    endtask

    task automatic test_single();
        logic [PHV_LEN-1:0] p;
        p = make_phv(32'h2222_0000, 4'b0100);
        phv_in[2*PHV_LEN +: PHV_LEN] = p;
        phv_in_valid = 4'b0100; phv_out_ready = 1'b1;
        tick();
        phv_in_valid = '0;
        tests_run++; if (phv_out_valid !== 1'b0 || phv_in_ready !== 4'b1011) begin tests_failed++; $display("FAIL single_accept got valid=%b ready=%b exp 0/1011", phv_out_valid, phv_in_ready); end
        tick();
        tests_run++; if (phv_out_valid !== 1'b1 || queue_idx_out !== 2'd2) begin tests_failed++; $display("FAIL single_out got valid=%b idx=%0d exp 1/2", phv_out_valid, queue_idx_out); end
        tests_run++; if (phv_out !== p || phv_out[QUEUE_BIT_OFF +: 4] !== 4'b0100) begin tests_failed++; $display("FAIL single_data got field=%b lsw=%h exp 0100/%h", phv_out[QUEUE_BIT_OFF +: 4], phv_out[31:0], p[31:0]); end
        tests_run++; if (q_cnt[2*CNT_WIDTH +: CNT_WIDTH] !== 32'd1 || q_err !== 4'b0000) begin tests_failed++; $display("FAIL single_cnt got cnt2=%0d err=%b exp 1/0000", q_cnt[2*CNT_WIDTH +: CNT_WIDTH], q_err); end
        tests_run++; if (phv_in_ready !== 4'b1111) begin tests_failed++; $display("FAIL single_ready got=%b exp=1111", phv_in_ready); end
        tick();
        tests_run++; if (phv_out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drain got valid=%b exp 0", phv_out_valid); end
    endtask

    task automatic test_all_four();
        logic [PHV_LEN-1:0] exp_phv [4];
        do_reset();
        phv_out_ready = 1'b1;
        for (int q = 0; q < 4; q++) begin
            exp_phv[q] = make_phv(32'hA000_0000 + 32'(q), 4'(1 << q));
            phv_in[q*PHV_LEN +: PHV_LEN] = exp_phv[q];
        end
        phv_in_valid = 4'b1111;
        tick();
        phv_in_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (phv_out_valid !== 1'b1 || queue_idx_out !== 2'(k) || phv_out !== exp_phv[k] || phv_in_ready !== 4'((1 << (k + 1)) - 1)) begin
                tests_failed++;
                $display("FAIL all_four_%0d got valid=%b idx=%0d lsw=%h ready=%b exp 1/%0d/%h/%b", k, phv_out_valid, queue_idx_out, phv_out[31:0], phv_in_ready, k, exp_phv[k][31:0], 4'((1 << (k + 1)) - 1));
            end
        end
        tick();
    endtask

    task automatic test_multicast();
        logic [PHV_LEN-1:0] p;
        p = make_phv(32'h5EED_CAFE, 4'b1111);
        phv_in[0 +: PHV_LEN] = p;
        phv_in[3*PHV_LEN +: PHV_LEN] = p;
        phv_in_valid = 4'b1001;
        tick();
        phv_in_valid = '0;
        tick();
        tests_run++; if (queue_idx_out !== 2'd0 || phv_out !== make_phv(32'h5EED_CAFE, 4'b0001)) begin tests_failed++; $display("FAIL mcast_first got idx=%0d field=%b exp 0/0001", queue_idx_out, phv_out[QUEUE_BIT_OFF +: 4]); end
        tick();
        tests_run++; if (queue_idx_out !== 2'd3 || phv_out !== make_phv(32'h5EED_CAFE, 4'b1000)) begin tests_failed++; $display("FAIL mcast_second got idx=%0d field=%b exp 3/1000", queue_idx_out, phv_out[QUEUE_BIT_OFF +: 4]); end
        tests_run++; if (q_err !== 4'b0000) begin tests_failed++; $display("FAIL mcast_err got=%b exp=0000", q_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [PHV_LEN-1:0] exp_phv [5];
        int order [4] = '{1, 2, 3, 0};
        phv_out_ready = 1'b0;
        for (int q = 0; q < 4; q++) begin
            exp_phv[q] = make_phv(32'hB000_0000 + 32'(q), 4'(1 << q));
            phv_in[q*PHV_LEN +: PHV_LEN] = exp_phv[q];
        end
        exp_phv[4] = make_phv(32'hB000_0004, 4'b0001);
        phv_in_valid = 4'b1111;
        tick();
        phv_in[0 +: PHV_LEN] = exp_phv[4];
        phv_in_valid = 4'b0001;
        tick();
        tick();
        phv_in_valid = '0;
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (phv_out_valid !== 1'b1 || queue_idx_out !== 2'd0 || phv_out !== exp_phv[0] || phv_in_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL hold_%0d got valid=%b idx=%0d lsw=%h ready=%b exp 1/0/%h/0000", c, phv_out_valid, queue_idx_out, phv_out[31:0], phv_in_ready, exp_phv[0][31:0]);
            end
            tick();
        end
        phv_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (phv_out_valid !== 1'b1 || queue_idx_out !== 2'(order[k]) || phv_out !== exp_phv[k + 1]) begin
                tests_failed++;
                $display("FAIL release_%0d got valid=%b idx=%0d lsw=%h exp 1/%0d/%h", k, phv_out_valid, queue_idx_out, phv_out[31:0], order[k], exp_phv[k + 1][31:0]);
            end
        end
        tick();
        tests_run++; if (phv_out_valid !== 1'b0) begin tests_failed++; $display("FAIL release_drain got valid=%b exp 0", phv_out_valid); end
    endtask

    task automatic test_qerr();
        phv_in[PHV_LEN +: PHV_LEN] = make_phv(32'hE110_0001, 4'b0000);
        phv_in_valid = 4'b0010;
        tick();
        phv_in_valid = '0;
        tests_run++; if (q_err !== 4'b0010) begin tests_failed++; $display("FAIL qerr_set got=%b exp=0010", q_err); end
        tick();
        tests_run++; if (queue_idx_out !== 2'd1 || phv_out !== make_phv(32'hE110_0001, 4'b0010)) begin tests_failed++; $display("FAIL qerr_fwd got idx=%0d field=%b exp 1/0010", queue_idx_out, phv_out[QUEUE_BIT_OFF +: 4]); end
        tests_run++; if (q_cnt[CNT_WIDTH +: CNT_WIDTH] !== 32'd3) begin tests_failed++; $display("FAIL qerr_cnt got=%0d exp=3", q_cnt[CNT_WIDTH +: CNT_WIDTH]); end
        tick(); tick(); tick();
        tests_run++; if (q_err !== 4'b0010) begin tests_failed++; $display("FAIL qerr_sticky got=%b exp=0010", q_err); end
    endtask

    task automatic test_reset_mid();
        phv_out_ready = 1'b0;
        for (int q = 0; q < 4; q++)
            phv_in[q*PHV_LEN +: PHV_LEN] = make_phv(32'hD000_0000 + 32'(q), 4'(1 << q));
        phv_in_valid = 4'b1111;
        tick();
        phv_in_valid = '0;
        tick();
        tests_run++; if (phv_out_valid !== 1'b1 || queue_idx_out !== 2'd2) begin tests_failed++; $display("FAIL mid_pre got valid=%b idx=%0d exp 1/2", phv_out_valid, queue_idx_out); end
        axis_rst = 1'b1;
        tick();
        tests_run++; if (phv_out_valid !== 1'b0 || q_cnt !== '0 || q_err !== 4'b0000 || phv_in_ready !== 4'b0000) begin tests_failed++; $display("FAIL mid_reset got valid=%b cnt0=%0d err=%b ready=%b exp 0/0/0000/0000", phv_out_valid, q_cnt[CNT_WIDTH-1:0], q_err, phv_in_ready); end
        axis_rst = 1'b0;
        phv_out_ready = 1'b1;
        tick();
        tests_run++; if (phv_in_ready !== 4'b1111) begin tests_failed++; $display("FAIL mid_ready got=%b exp=1111", phv_in_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            tests_run++; if (phv_out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_ghost_%0d got valid=%b idx=%0d exp 0", c, phv_out_valid, queue_idx_out); end
        end
        phv_in[PHV_LEN +: PHV_LEN] = make_phv(32'hF000_0001, 4'b0010);
        phv_in[3*PHV_LEN +: PHV_LEN] = make_phv(32'hF000_0003, 4'b1000);
        phv_in_valid = 4'b1010;
        tick();
        phv_in_valid = '0;
        tick();
        tests_run++; if (phv_out_valid !== 1'b1 || queue_idx_out !== 2'd1) begin tests_failed++; $display("FAIL mid_ptr_first got valid=%b idx=%0d exp 1/1", phv_out_valid, queue_idx_out); end
        tick();
        tests_run++; if (phv_out_valid !== 1'b1 || queue_idx_out !== 2'd3) begin tests_failed++; $display("FAIL mid_ptr_second got valid=%b idx=%0d exp 1/3", phv_out_valid, queue_idx_out); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge axis_clk);
        test_reset();
        test_single();
        test_all_four();
        test_multicast();
        test_back_to_back();
        test_qerr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
